// File: rtl/i2c_crc_word_parser_if.sv
// i2c_crc_word_parser_if: byte-stream in / checked-word out bundle for the I2C CRC word parser
// Ports (master = byte source and word sink, slave = parser):
//   frame_start, byte_valid, byte_data[7:0]          master -> slave
//   word_valid, word_data[15:0], word_index[2:0],
//   frame_done, crc_error, err_index[2:0], busy      slave -> master
interface i2c_crc_word_parser_if;
   logic        frame_start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        word_valid;
   logic [15:0] word_data;
   logic [2:0]  word_index;
   logic        frame_done;
   logic        crc_error;
   logic [2:0]  err_index;
   logic        busy;
   modport master (
      output frame_start, byte_valid, byte_data,
      input  word_valid, word_data, word_index, frame_done, crc_error, err_index, busy
   );
   modport slave (
      input  frame_start, byte_valid, byte_data,
      output word_valid, word_data, word_index, frame_done, crc_error, err_index, busy
   );
endinterface

// File: rtl/i2c_crc_word_parser.sv
// i2c_crc_word_parser: splits an I2C byte stream into NUM_WORDS 16-bit words, each optionally CRC-8 checked
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave modport: frame_start/byte_valid/byte_data in; word_valid/word_data/word_index,
//          frame_done, crc_error/err_index and busy out (all pulses registered, one cycle wide)
module i2c_crc_word_parser #(
   parameter int         NUM_WORDS = 2,
   parameter int         CRC_EN    = 1,
   parameter logic [7:0] CRC_POLY  = 8'h31,
   parameter logic [7:0] CRC_INIT  = 8'hFF
) (
   input logic                  clk,
   input logic                  rst,
   i2c_crc_word_parser_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MSB, LSB, CHK} state_t;
   state_t      state_q, state_d;
   logic [7:0]  crc_q, crc_d, msb_q, msb_d, lsb_q, lsb_d;
   logic [2:0]  idx_q, idx_d, word_index_q, word_index_d, err_index_q, err_index_d;
   logic [15:0] word_data_q, word_data_d;
   logic        word_valid_q, word_valid_d, frame_done_q, frame_done_d, crc_error_q, crc_error_d;
   logic        accept, last, match, emit, bad;
   function automatic logic [7:0] step(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
      return r;
   endfunction
   // A byte arriving together with frame_start is dropped; the restart takes priority.
   assign accept = bus.byte_valid && !bus.frame_start;
   assign last   = idx_q == 3'(NUM_WORDS - 1);
   assign match  = bus.byte_data == crc_q;
   assign emit   = accept && ((state_q == LSB && CRC_EN == 0) || (state_q == CHK && match));
   assign bad    = accept && state_q == CHK && !match;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         crc_q        <= CRC_INIT;
         msb_q        <= '0;
         lsb_q        <= '0;
         idx_q        <= '0;
         word_data_q  <= '0;
         word_index_q <= '0;
         err_index_q  <= '0;
         word_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         crc_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         msb_q        <= msb_d;
         lsb_q        <= lsb_d;
         idx_q        <= idx_d;
         word_data_q  <= word_data_d;
         word_index_q <= word_index_d;
         err_index_q  <= err_index_d;
         word_valid_q <= word_valid_d;
         frame_done_q <= frame_done_d;
         crc_error_q  <= crc_error_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (bus.frame_start) state_d = MSB;
      else if (bus.byte_valid)
         case (state_q)
            MSB:     state_d = LSB;
            LSB:     state_d = CRC_EN != 0 ? CHK : (last ? IDLE : MSB);
            CHK:     state_d = (match && !last) ? MSB : IDLE;
            default: state_d = IDLE;
         endcase
   end
   always_comb begin
      crc_d        = bus.frame_start ? CRC_INIT :
                     (accept && state_q == MSB) ? step(CRC_INIT, bus.byte_data) :
                     (accept && state_q == LSB) ? step(crc_q, bus.byte_data) : crc_q;
      msb_d        = (accept && state_q == MSB) ? bus.byte_data : msb_q;
      lsb_d        = (accept && state_q == LSB) ? bus.byte_data : lsb_q;
      idx_d        = bus.frame_start ? 3'd0 : emit ? (last ? 3'd0 : idx_q + 3'd1) : idx_q;
      // Without CRC the word completes on the LSB byte itself, before lsb_q is loaded.
      word_data_d  = emit ? {msb_q, CRC_EN != 0 ? lsb_q : bus.byte_data} : word_data_q;
      word_index_d = emit ? idx_q : word_index_q;
      err_index_d  = bad ? idx_q : err_index_q;
      word_valid_d = emit;
      frame_done_d = emit && last;
      crc_error_d  = bad;
   end
   assign bus.word_valid = word_valid_q;
   assign bus.word_data  = word_data_q;
   assign bus.word_index = word_index_q;
   assign bus.frame_done = frame_done_q;
   assign bus.crc_error  = crc_error_q;
   assign bus.err_index  = err_index_q;
   assign bus.busy       = state_q != IDLE;
endmodule
